alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage_if.sv | 29 ++
 rtl/alu_exec_stage.sv | 137 +++++++++++++
 tb/tb_alu_exec_stage.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_stage_if.sv
// Handshake and data bundle for the ALU execute stage: upstream operation in, head result out.
interface alu_exec_stage_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_ctl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [4:0]   rd_in;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  logic         illegal;
  logic [4:0]   rd_out;

  modport master (
    output in_valid, alu_ctl, a, b, rd_in, flush, out_ready,
    input  in_ready, out_valid, result, zero, ovf, illegal, rd_out
  );

  modport slave (
    input  in_valid, alu_ctl, a, b, rd_in, flush, out_ready,
    output in_ready, out_valid, result, zero, ovf, illegal, rd_out
  );
endinterface

// File: rtl/alu_exec_stage.sv
// ALU execute stage with a 2-entry in-order result buffer and registered head outputs.
// Optional feature: define ALU_EXEC_OVF_EN to flag signed overflow on ADD/SUB.
module alu_exec_stage #(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  alu_exec_stage_if.slave  bus
);

  // Entry layout: {result, zero, ovf, illegal, rd}
  localparam int EW = W + 8;

  logic [EW-1:0] mem_r [2];
  logic [EW-1:0] mem_nxt_s [2];
  logic [1:0]    count_r;
  logic [1:0]    count_nxt_s;
  logic          wr_ptr_r;
  logic          wr_nxt_s;
  logic          rd_ptr_r;
  logic          rd_nxt_s;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [EW-1:0] head_r;
  logic [EW-1:0] head_nxt_s;
  logic [EW-1:0] entry_s;
  logic          push_s;
  logic          pop_s;

  function automatic logic [EW-1:0] alu_entry(
    input logic [2:0]   ctl,
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic [4:0]   rd
  );
    logic [W-1:0] res;
    logic [W-1:0] sum;
    logic [W-1:0] diff;
    logic         ovf;
    logic         ill;
    sum  = x + y;
    diff = x - y;
    res  = {W{1'b0}};
    ovf  = 1'b0;
    ill  = 1'b0;
    case (ctl)
      3'd0: res = x & y;
      3'd1: res = x | y;
      3'd2: begin
        res = sum;
`ifdef ALU_EXEC_OVF_EN
        ovf = (x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]);
`endif
      end
      3'd3: begin
        res = diff;
`ifdef ALU_EXEC_OVF_EN
        ovf = (x[W-1] != y[W-1]) && (diff[W-1] != x[W-1]);
`endif
      end
      3'd4: res = {{(W-1){1'b0}}, ($signed(x) < $signed(y))};
      default: begin
        res = {W{1'b0}};
        ill = 1'b1;
      end
    endcase
    return {res, (res == {W{1'b0}}), ovf, ill, rd};
  endfunction

  assign entry_s = alu_entry(bus.alu_ctl, bus.a, bus.b, bus.rd_in);
  assign push_s  = bus.in_valid & in_ready_r & ~bus.flush;
  assign pop_s   = out_valid_r & bus.out_ready & ~bus.flush;

  // Next-state of buffer, pointers and occupancy; the head is precomputed so outputs can be registered
  always_comb begin
    count_nxt_s  = count_r;
    wr_nxt_s     = wr_ptr_r;
    rd_nxt_s     = rd_ptr_r;
    mem_nxt_s[0] = mem_r[0];
    mem_nxt_s[1] = mem_r[1];
    if (bus.flush) begin
      count_nxt_s = 2'd0;
      wr_nxt_s    = 1'b0;
      rd_nxt_s    = 1'b0;
    end else begin
      if (push_s) begin
        mem_nxt_s[wr_ptr_r] = entry_s;
        wr_nxt_s            = ~wr_ptr_r;
      end else begin
        wr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_nxt_s = ~rd_ptr_r;
      end else begin
        rd_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + 2'd1;
        2'b01:   count_nxt_s = count_r - 2'd1;
        default: count_nxt_s = count_r;
      endcase
    end
    head_nxt_s = (count_nxt_s != 2'd0) ? mem_nxt_s[rd_nxt_s] : {EW{1'b0}};
  end

  // State and registered output update; reset wins over flush, push and pop
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r[0]    <= {EW{1'b0}};
      mem_r[1]    <= {EW{1'b0}};
      count_r     <= 2'd0;
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      head_r      <= {EW{1'b0}};
    end else begin
      mem_r[0]    <= mem_nxt_s[0];
      mem_r[1]    <= mem_nxt_s[1];
      count_r     <= count_nxt_s;
      wr_ptr_r    <= wr_nxt_s;
      rd_ptr_r    <= rd_nxt_s;
      in_ready_r  <= (count_nxt_s < 2'd2);
      out_valid_r <= (count_nxt_s != 2'd0);
      head_r      <= head_nxt_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = head_r[EW-1:8];
  assign bus.zero      = head_r[7];
  assign bus.ovf       = head_r[6];
  assign bus.illegal   = head_r[5];
  assign bus.rd_out    = head_r[4:0];

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized self-checking bench for alu_exec_stage against a queue-based reference model.
module tb_alu_exec_stage;
  localparam int W = 32;
`ifdef ALU_EXEC_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    bit          z;
    bit          o;
    bit          il;
    logic [4:0]  rd;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_exec_stage_if #(.W(W)) bus ();
  alu_exec_stage #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int   checks   = 0;
  int   failures = 0;
  ent_t q[$];
  bit   m_ready  = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t ref_op(input logic [2:0] ctl, input logic [31:0] x,
                                  input logic [31:0] y, input logic [4:0] rd);
    ent_t   e;
    longint full;
    e.res = 32'd0; e.o = 1'b0; e.il = 1'b0; e.rd = rd;
    case (ctl)
      3'd0: e.res = x & y;
      3'd1: e.res = x | y;
      3'd2: begin
        full  = longint'($signed(x)) + longint'($signed(y));
        e.res = x + y;
        e.o   = OVF_EN && (full != longint'($signed(e.res)));
      end
      3'd3: begin
        full  = longint'($signed(x)) - longint'($signed(y));
        e.res = x - y;
        e.o   = OVF_EN && (full != longint'($signed(e.res)));
      end
      3'd4: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic compare_all();
    ent_t h;
    h = '{res: 32'd0, z: 1'b0, o: 1'b0, il: 1'b0, rd: 5'd0};
    if (q.size() != 0) h = q[0];
    check_eq("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    check_eq("in_ready",  64'(bus.in_ready),  64'(m_ready));
    check_eq("result",    64'(bus.result),    64'(h.res));
    check_eq("zero",      64'(bus.zero),      64'(h.z));
    check_eq("ovf",       64'(bus.ovf),       64'(h.o));
    check_eq("illegal",   64'(bus.illegal),   64'(h.il));
    check_eq("rd_out",    64'(bus.rd_out),    64'(h.rd));
  endtask

  // One clock: predict from pre-edge inputs, advance the model, then compare after the edge
  task automatic tick(output bit acc);
    bit   push;
    bit   pop;
    ent_t e;
    e    = ref_op(bus.alu_ctl, bus.a, bus.b, bus.rd_in);
    push = !rst && !bus.flush && bus.in_valid && m_ready;
    pop  = !rst && !bus.flush && bus.out_ready && (q.size() != 0);
    @(posedge clk);
    if (rst || bus.flush) begin
      q.delete();
    end else begin
      if (pop) q.delete(0);
      if (push) q.push_back(e);
    end
    m_ready = (q.size() < 2);
    acc = push;
    #1;
    compare_all();
  endtask

  task automatic step();
    bit d;
    tick(d);
  endtask

  task automatic set_op(input bit v, input logic [2:0] ctl, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] rd);
    bus.in_valid = v;
    bus.alu_ctl  = ctl;
    bus.a        = x;
    bus.b        = y;
    bus.rd_in    = rd;
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] edges [6];
    edges = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h5};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
    return $urandom();
  endfunction

  initial begin
    bit acc;
    int guard;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    set_op(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

    // ADD 5+7 -> 12 one cycle later
    bus.out_ready = 1'b1;
    set_op(1'b1, 3'd2, 32'd5, 32'd7, 5'd3);
    step();
    check_eq("add_valid", 64'(bus.out_valid), 64'd1);
    check_eq("add_res",   64'(bus.result),    64'd12);
    check_eq("add_zero",  64'(bus.zero),      64'd0);
    check_eq("add_rd",    64'(bus.rd_out),    64'd3);

    set_op(1'b1, 3'd3, 32'd9, 32'd9, 5'd4);
    step();
    check_eq("sub_zero", 64'(bus.zero), 64'd1);
    set_op(1'b1, 3'd4, 32'hFFFFFFFF, 32'd1, 5'd5);
    step();
    check_eq("slt_neg", 64'(bus.result), 64'd1);
    set_op(1'b1, 3'd4, 32'd1, 32'hFFFFFFFF, 5'd6);
    step();
    check_eq("slt_pos", 64'(bus.result), 64'd0);
    set_op(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    step();

    // Back-pressure: fill both entries, hold a third, then drain in order
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_op(1'b1, 3'd2, 32'(i * 10), 32'd1, 5'(i + 8));
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 6) begin
        if (guard == 2) bus.out_ready = 1'b1;
        tick(acc);
        guard++;
      end
      check_eq("push_accepted", 64'(acc), 64'd1);
      if (i == 1) check_eq("full_in_ready", 64'(bus.in_ready), 64'd0);
    end
    set_op(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 3; i++) step();

    // Illegal code, then flush with two held
    bus.out_ready = 1'b0;
    set_op(1'b1, 3'd6, 32'h1234, 32'h5678, 5'd9);
    step();
    check_eq("ill_res",  64'(bus.result),  64'd0);
    check_eq("ill_flag", 64'(bus.illegal), 64'd1);
    check_eq("ill_zero", 64'(bus.zero),    64'd1);
    set_op(1'b1, 3'd1, 32'hF0, 32'h0F, 5'd10);
    step();
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.flush = 1'b0;
    check_eq("flush_valid", 64'(bus.out_valid), 64'd0);
    check_eq("flush_ready", 64'(bus.in_ready),  64'd1);

    // Signed overflow
    set_op(1'b1, 3'd2, 32'h7FFFFFFF, 32'd1, 5'd11);
    step();
    check_eq("ovf_res",  64'(bus.result), 64'h80000000);
    check_eq("ovf_flag", 64'(bus.ovf),    64'(OVF_EN));

    // Reset with one held entry and a pending input
    bus.out_ready = 1'b0;
    set_op(1'b1, 3'd0, 32'hFF, 32'h0F, 5'd12);
    step();
    rst = 1'b1;
    step();
    check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b0;
    set_op(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    step();
    check_eq("rst_not_accepted", 64'(bus.out_valid), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      set_op($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rand_operand(),
             rand_operand(), 5'($urandom_range(0, 31)));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 19) == 0);
      rst           = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    bus.flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
